// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the
// decode-stage integer register file.
package regfile_pkg;

  localparam int XLEN_DEF         = 32;
  localparam int NUM_REGS_DEF     = 32;
  localparam int NUM_RD_PORTS_DEF = 2;

  typedef logic [XLEN_DEF-1:0] xlen_t;
  typedef logic [4:0]          reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits set on
// issue, cleared on writeback, wiped on flush/reset.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NUM_REGS     = NUM_REGS_DEF,
  parameter  int NUM_RD_PORTS = NUM_RD_PORTS_DEF,
  localparam int AW           = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_en,
  input  logic [AW-1:0]                issue_addr,
  input  logic                         wb_en,
  input  logic [AW-1:0]                wb_addr,
  input  logic                         flush,
  input  logic [NUM_RD_PORTS-1:0][AW-1:0] rs_addr,
  output logic [NUM_RD_PORTS-1:0]      busy_out
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;

  // Clear first so a same-cycle issue re-marks the
  // register: the newer producer wins.
  always_comb begin
    busy_nxt = busy;
    if (wb_en)
      busy_nxt[wb_addr] = 1'b0;
    if (flush)
      busy_nxt = '0;
    else if (issue_en && issue_addr != '0)
      busy_nxt[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

  always_comb begin
    busy_out = '0;
    for (int i = 0; i < NUM_RD_PORTS; i++)
      busy_out[i] = busy[rs_addr[i]];
  end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: N-read/1-write register file with
// optional writeback bypass and busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN         = XLEN_DEF,
  parameter  int NUM_REGS     = NUM_REGS_DEF,
  parameter  int NUM_RD_PORTS = NUM_RD_PORTS_DEF,
  parameter  int BYPASS       = 1,
  localparam int AW           = $clog2(NUM_REGS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_RD_PORTS-1:0][AW-1:0] rs_addr,
  output logic [NUM_RD_PORTS-1:0][XLEN-1:0] rd_data,
  output logic [NUM_RD_PORTS-1:0]         rs_busy,
  input  logic                            wb_en,
  input  logic [AW-1:0]                   wb_addr,
  input  logic [XLEN-1:0]                 wb_data,
  input  logic                            issue_en,
  input  logic [AW-1:0]                   issue_addr,
  input  logic                            flush
);

  logic [XLEN-1:0]         regs [NUM_REGS];
  logic [NUM_RD_PORTS-1:0] sb_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++)
        regs[r] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS     (NUM_REGS),
    .NUM_RD_PORTS (NUM_RD_PORTS)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .flush      (flush),
    .rs_addr    (rs_addr),
    .busy_out   (sb_busy)
  );

  for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_rd
    logic hit;
    logic is_zero;

    assign hit = (BYPASS != 0) && wb_en &&
                 (wb_addr == rs_addr[i]);
    assign is_zero = (rs_addr[i] == '0);

    // r0 reads zero even when a bypass would hit it
    assign rd_data[i] = is_zero ? '0 :
                        hit     ? wb_data :
                                  regs[rs_addr[i]];
    assign rs_busy[i] = sb_busy[i] & ~hit;
  end

endmodule
